// File: rtl/ula_pkg.sv
// Shared definitions for the 3-bit ALU and its accumulator controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ula_pkg;

    localparam int ULA_WIDTH = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_NEG = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/ula.sv
// Combinational 8-function ALU; cout is carry for add, borrow for sub, else 0.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; divide by zero returns all ones.
module ula
    import ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        cout   = 1'b0;
        case (sel)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
            end
            OP_SUB: begin
                result = a - b;
                cout   = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_NEG: result = ~a + ONE;
            OP_DIV: result = (b == '0) ? '1 : a / b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ula_acc_ctrl.sv
// Accumulator controller feeding the ALU and capturing its result (optional ULA_ACC_DIV0_CHK_EN).
// Latency: load 1 cycle, ALU op 2 cycles (accept edge + capture edge).
// Backpressure: cmd_ready low only in EXEC; a held cmd_valid is taken on return to IDLE.
module ula_acc_ctrl
    import ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_e,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             done_q, done_d;
`ifdef ULA_ACC_DIV0_CHK_EN
    logic             e_q, e_d;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        sel_d   = sel_q;
        c_d     = c_q;
        z_d     = z_q;
        done_d  = 1'b0;
`ifdef ULA_ACC_DIV0_CHK_EN
        e_d     = e_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_d  = cmd_data;
                        c_d    = 1'b0;
                        z_d    = (cmd_data == '0);
                        done_d = 1'b1;
`ifdef ULA_ACC_DIV0_CHK_EN
                        e_d    = 1'b0;
`endif
                    end else begin
                        b_d     = cmd_data;
                        sel_d   = cmd_op;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
`ifdef ULA_ACC_DIV0_CHK_EN
                // Divide by zero keeps acc/carry so software can retry with a valid divisor.
                if (sel_q == OP_DIV && b_q == '0) begin
                    e_d = 1'b1;
                    z_d = (acc_q == '0);
                end else begin
                    acc_d = alu_result;
                    c_d   = alu_cout;
                    z_d   = (alu_result == '0);
                    e_d   = 1'b0;
                end
`else
                acc_d = alu_result;
                c_d   = alu_cout;
                z_d   = (alu_result == '0);
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef ULA_ACC_DIV0_CHK_EN
            e_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            c_q     <= c_d;
            z_q     <= z_d;
            done_q  <= done_d;
`ifdef ULA_ACC_DIV0_CHK_EN
            e_q     <= e_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign acc       = acc_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign done      = done_q;
`ifdef ULA_ACC_DIV0_CHK_EN
    assign flag_e    = e_q;
`else
    assign flag_e    = 1'b0;
`endif

endmodule

// File: doc/ula_acc_ctrl.md
# ula_acc_ctrl

Accumulator controller that sits directly upstream of the 3-bit ALU (`ula`) and also consumes its output. It accepts operation commands over a valid/ready handshake and drives the ALU's `a`/`b`/`sel` inputs from an internal accumulator and an operand register. It captures the ALU's `result`/`cout` back into the accumulator and flag registers. Together with the ALU it forms the complete sequential datapath of the lab CPU core.

## Interface
Parameters:
- `WIDTH`, 3, datapath width; must match the ALU's `a`/`b`/`result` width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_load` in 1: 1 loads `cmd_data` directly into the accumulator; 0 runs an ALU operation.
- `cmd_op` in 3: ALU opcode.
  - 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 110 negate, 111 divide.
- `cmd_data` in WIDTH: operand B, or the load value.
- `alu_a` out WIDTH: to ALU `a`; always equals `acc`.
- `alu_b` out WIDTH: to ALU `b`; registered operand.
- `alu_sel` out 3: to ALU `sel`; registered opcode.
- `alu_result` in WIDTH: from ALU `result`.
- `alu_cout` in 1: from ALU `cout`.
- `acc` out WIDTH: accumulator.
- `flag_c` out 1: carry/borrow from the last operation.
- `flag_z` out 1: accumulator is zero after the last update.
- `flag_e` out 1: error flag; only present in logic when `ULA_ACC_DIV0_CHK_EN` is defined, otherwise tied 0.
- `done` out 1: one-cycle pulse per completed command.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - EXEC: `cmd_ready`=0.
- `cmd_ready` is decoded from the state (IDLE), not registered separately.
- Accept: `cmd_valid && cmd_ready` at a rising edge.
- Load command (`cmd_load`=1), at the accept edge:
  - `acc` ← `cmd_data`.
  - `flag_c` ← 0; `flag_e` ← 0; `flag_z` ← (`cmd_data`==0).
  - `done` ← 1; state stays IDLE.
- ALU command (`cmd_load`=0), at the accept edge:
  - `alu_b` ← `cmd_data`; `alu_sel` ← `cmd_op`; state → EXEC.
- EXEC lasts one cycle, during which the ALU settles combinationally. At the next edge:
  - `acc` ← `alu_result`; `flag_c` ← `alu_cout`; `flag_z` ← (`alu_result`==0).
  - `done` ← 1; state → IDLE.
- `flag_c` semantics:
  - Meaningful for add (carry out) and sub (borrow: 1 when acc < B).
  - For all other ops the ALU drives 0, so `flag_c` clears.
- Unary ops (101, 110) ignore `alu_b`; it is still loaded from `cmd_data`.
- Arithmetic is modulo 2^WIDTH, and the accumulator wraps silently. Example: 7+1 → 0 with `flag_c`=1 and `flag_z`=1.
- `cmd_valid` seen while in EXEC is ignored (ready is low); the command is not dropped as long as the master holds valid.
- `alu_b` and `alu_sel` hold their last values in IDLE.
- Reset (any time, including mid-EXEC):
  - State → IDLE.
  - `acc`, `alu_b`, `alu_sel`, `flag_c`, `flag_z`, `flag_e`, `done` → 0.
  - No capture and no `done` for an aborted command.
  - `cmd_ready`=1 during and after reset.

## Timing
- Load: 1 cycle. `acc` and flags are visible, and `done`=1, in the cycle after the accept edge.
- ALU op: 2 cycles. With accept at edge k, `acc`, flags and `done` update at edge k+1; `cmd_ready` is high again from edge k+1.
- Throughput:
  - One ALU command per 2 cycles.
  - Back-to-back loads: one per cycle.
- `done` is high for exactly one cycle per command and is never asserted for two consecutive cycles by a single command.
- `alu_a`, `alu_b` and `alu_sel` are all register outputs, so the ALU input path has no combinational path from the `cmd_*` inputs.

## Configuration
`ULA_ACC_DIV0_CHK_EN`:
- Defined:
  - Op 111 with `alu_b`==0 at the EXEC-end edge leaves `acc` and `flag_c` unchanged and sets `flag_e`=1, `flag_z`=(`acc`==0), `done`=1.
  - Any other completed command clears `flag_e`.
- Undefined:
  - No check; divide-by-zero captures whatever the ALU returns (unspecified).
  - `flag_e` is constant 0.

## Structure
- Shared package `ula_pkg`:
  - `WIDTH` default.
  - Opcode localparams `OP_ADD`..`OP_DIV` (000–111).
  - State enum `ST_IDLE`/`ST_EXEC`.
- The same package is used by the ALU and the top level.
- No sub-module; `ula_acc_ctrl` and the ALU are sibling instances wired at the core top level. The bench instantiates both.

## Test plan
- Reset then idle → `acc`=0, all flags 0, `done`=0, `cmd_ready`=1, `alu_sel`=0.
- Load 7, then sub 2 → `acc`=5, `flag_c`=0, `flag_z`=0, `done` pulses 2 cycles after the sub is accepted.
- Load 1, then sub 2 → `acc`=7, `flag_c`=1 (borrow).
- Load 7, then add 1 → `acc`=0, `flag_c`=1, `flag_z`=1.
- Load 6, then div 3 → `acc`=2. With the macro defined, load 6 then div 0 → `acc`=6, `flag_e`=1; the next add 0 clears `flag_e`.
- Assert `rst_n`=0 mid-EXEC of add → `acc`=0, no `done`, `cmd_ready`=1. A held `cmd_valid` during EXEC is accepted exactly once after return to IDLE.
